// File: rtl/uart_unpack_pkg.sv
// Shared types and helpers for the UART-unpack lane arbiter.
package uart_unpack_pkg;

  localparam int DW_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  function automatic int lane_w(input int n_ch);
    return (n_ch > 2) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin lane picker: first requesting lane after `last`, wrapping modulo N_CH.
module uart_rr_pick
  import uart_unpack_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int IW   = lane_w(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [IW-1:0]   last,
  output logic            found,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] cand;

  // Offsets are scanned farthest-first so the nearest lane after `last` wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int off = N_CH; off >= 1; off--) begin
      cand = IW'((int'(last) + off) % N_CH);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_unpack_arb.sv
// Round-robin burst arbiter draining N_CH FWFT lane FIFOs into one registered valid/ready stream.
//   state | meaning
//   IDLE  | search for an enabled, non-empty lane after the last one served
//   XFER  | pop the granted lane whenever the output register can load
//   GAP   | one turnaround cycle, no pops, output may still drain
module uart_unpack_arb
  import uart_unpack_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int DW        = DW_DEFAULT,
  parameter int MAX_BURST = 16
) (
  input  logic                    i_clk148p5M,
  input  logic                    i_rst_n,
  input  logic [N_CH-1:0]         i_empty,
  input  logic [N_CH*DW-1:0]      i_data,
  input  logic [N_CH-1:0]         i_enable,
  output logic [N_CH-1:0]         o_rd_en,
  output logic                    o_valid,
  output logic [DW-1:0]           o_data,
  output logic [lane_w(N_CH)-1:0] o_chan,
  input  logic                    i_ready,
  output logic [N_CH-1:0]         o_grant,
  output logic                    o_busy
);

  localparam int            IW         = lane_w(N_CH);
  localparam int            CW         = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX  = CW'(MAX_BURST);
  localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

  arb_state_e      state, state_nxt;
  logic [IW-1:0]   grant_idx, last_idx, pick_idx;
  logic [CW-1:0]   burst_cnt;
  logic [N_CH-1:0] lane_req;
  logic            pick_found, load, lane_empty, lane_en, pop, leave;

  assign lane_req = i_enable & ~i_empty;

  uart_rr_pick #(.N_CH(N_CH), .IW(IW)) u_pick (
    .req   (lane_req),
    .last  (last_idx),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign load       = ~o_valid | i_ready;
  assign lane_empty = i_empty[grant_idx];
  assign lane_en    = i_enable[grant_idx];
  assign pop        = (state == ST_XFER) & load & ~lane_empty & lane_en;
  assign leave      = (state == ST_XFER) &
                      ((pop & (burst_cnt == BURST_LAST)) | (load & lane_empty) | ~lane_en);
  assign o_busy     = (state != ST_IDLE) | o_valid;

  always_comb begin
    o_grant = '0;
    o_rd_en = '0;
    if (state == ST_XFER) o_grant[grant_idx] = 1'b1;
    if (pop)              o_rd_en[grant_idx] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (pick_found) state_nxt = ST_XFER;
      ST_XFER: if (leave)      state_nxt = ST_GAP;
      ST_GAP:                  state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk148p5M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      grant_idx <= '0;
      last_idx  <= IW'(N_CH - 1);
      burst_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && pick_found) begin
        grant_idx <= pick_idx;
        burst_cnt <= '0;
      end else if (pop && burst_cnt != BURST_MAX) begin
        burst_cnt <= burst_cnt + CW'(1);
      end
      if (leave) last_idx <= grant_idx;
    end
  end

  // A stalled word is held because pop requires load, and load is low while stalled.
  always_ff @(posedge i_clk148p5M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_chan  <= '0;
    end else if (pop) begin
      o_valid <= 1'b1;
      o_data  <= i_data[int'(grant_idx)*DW +: DW];
      o_chan  <= grant_idx;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_unpack_arb.sv
// Randomized bench for uart_unpack_arb: lane FIFO queues, a word scoreboard and a cycle-level grant predictor.
module tb_uart_unpack_arb;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    empty, en;
  logic [N*DW-1:0] data;
  logic            ready;
  logic            sel;

  logic [N-1:0]    rd_en0, rd_en1, grant0, grant1, rd_en, grant;
  logic            valid0, valid1, busy0, busy1, valid, busy;
  logic [DW-1:0]   odata0, odata1, odata;
  logic [1:0]      chan0, chan1, chan;

  initial forever #5 clk = ~clk;

  uart_unpack_arb #(.N_CH(N), .DW(DW), .MAX_BURST(16)) dut0 (
    .i_clk148p5M(clk), .i_rst_n(rst_n), .i_empty(empty), .i_data(data), .i_enable(en),
    .o_rd_en(rd_en0), .o_valid(valid0), .o_data(odata0), .o_chan(chan0), .i_ready(ready),
    .o_grant(grant0), .o_busy(busy0));

  uart_unpack_arb #(.N_CH(N), .DW(DW), .MAX_BURST(1)) dut1 (
    .i_clk148p5M(clk), .i_rst_n(rst_n), .i_empty(empty), .i_data(data), .i_enable(en),
    .o_rd_en(rd_en1), .o_valid(valid1), .o_data(odata1), .o_chan(chan1), .i_ready(ready),
    .o_grant(grant1), .o_busy(busy1));

  assign rd_en = sel ? rd_en1 : rd_en0;
  assign grant = sel ? grant1 : grant0;
  assign valid = sel ? valid1 : valid0;
  assign busy  = sel ? busy1  : busy0;
  assign odata = sel ? odata1 : odata0;
  assign chan  = sel ? chan1  : chan0;

  logic [DW-1:0]   fifo [N][$];
  logic [DW+1:0]   sb [$];
  int              checks = 0, failures = 0;
  int              max_burst, last_lane, burst_cnt, delivered;
  int              pops [N];
  logic [N-1:0]    prev_grant, prev2_grant, prev_req, en_fix;
  bit              prev_leave, prev_valid, prev_ready, prev_popped;
  logic [DW-1:0]   prev_data;
  logic [1:0]      prev_chan;
  bit              rand_ready, rand_fill, ready_fix;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit bit_at(input logic [N-1:0] v, input int k);
    return v[k[1:0]];
  endfunction

  function automatic logic [N-1:0] onehot(input int k);
    logic [N-1:0] v;
    v = '0;
    if (k >= 0) v[k[1:0]] = 1'b1;
    return v;
  endfunction

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (bit_at(v, i)) return i;
    return -1;
  endfunction

  function automatic int rr_next(input logic [N-1:0] req, input int last);
    for (int i = 1; i <= N; i++) if (bit_at(req, (last + i) % N)) return (last + i) % N;
    return -1;
  endfunction

  function automatic bit drained();
    for (int k = 0; k < N; k++) if (fifo[k].size() != 0) return 1'b0;
    return (sb.size() == 0) && !busy;
  endfunction

  task automatic drive_inputs();
    for (int k = 0; k < N; k++) begin
      empty[k[1:0]]    = (fifo[k].size() == 0);
      data[k*DW +: DW] = (fifo[k].size() == 0) ? $urandom : fifo[k][0];
    end
  endtask

  task automatic fill(input int k, input int n);
    for (int i = 0; i < n; i++) fifo[k].push_back($urandom);
  endtask

  task automatic model_reset();
    sb.delete();
    last_lane   = N - 1;
    burst_cnt   = 0;
    prev_grant  = '0;
    prev2_grant = '0;
    prev_leave  = 1'b0;
    prev_valid  = 1'b0;
    prev_ready  = ready;
    prev_popped = 1'b0;
    prev_data   = '0;
    prev_chan   = '0;
    prev_req    = en & ~empty;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rd_en"}, rd_en, 0);
    check_eq({tag, "_valid"}, valid, 0);
    check_eq({tag, "_data"},  odata, 0);
    check_eq({tag, "_chan"},  chan,  0);
    check_eq({tag, "_grant"}, grant, 0);
    check_eq({tag, "_busy"},  busy,  0);
    check_eq({tag, "_dut1"},  |{rd_en1, grant1, valid1, busy1, chan1, odata1}, 0);
  endtask

  // One clock: predict and check at the falling edge, then apply pops and new stimulus.
  task automatic step();
    logic [N-1:0] exp_grant, exp_rd, rd_snap;
    bit           ld, popped, leave_now;
    int           g;
    @(negedge clk);
    if (prev_grant != 0) begin
      if (prev_leave) last_lane = idx_of(prev_grant);
      exp_grant = prev_leave ? '0 : prev_grant;
    end else if (prev2_grant != 0) begin
      exp_grant = '0;
    end else begin
      exp_grant = (prev_req != 0) ? onehot(rr_next(prev_req, last_lane)) : '0;
    end
    check_eq("grant", grant, exp_grant);
    if (grant != 0 && prev_grant == 0) burst_cnt = 0;
    check_eq("valid", valid, prev_popped | (prev_valid & ~prev_ready));
    if (prev_valid && !prev_ready) begin
      check_eq("hold_data", odata, prev_data);
      check_eq("hold_chan", chan, prev_chan);
    end
    ld     = !valid || ready;
    exp_rd = '0;
    g      = idx_of(grant);
    if (g >= 0 && ld && !bit_at(empty, g) && bit_at(en, g)) exp_rd = onehot(g);
    check_eq("rd_en", rd_en, exp_rd);
    check_eq("busy", busy, (grant != 0) || (prev_grant != 0) || valid);
    if (valid && ready) begin
      check_eq("sb_avail", sb.size() != 0, 1);
      if (sb.size() != 0) check_eq("word", {chan, odata}, sb.pop_front());
      delivered++;
    end
    rd_snap = rd_en;
    popped  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (bit_at(rd_snap, k) && !popped && fifo[k].size() != 0) begin
        popped = 1'b1;
        sb.push_back({k[1:0], fifo[k][0]});
        pops[k]++;
        burst_cnt++;
      end
    end
    leave_now = 1'b0;
    if (g >= 0)
      leave_now = (popped && burst_cnt == max_burst) || (ld && bit_at(empty, g)) || !bit_at(en, g);
    prev2_grant = prev_grant;
    prev_grant  = grant;
    prev_leave  = leave_now;
    prev_valid  = valid;
    prev_ready  = ready;
    prev_data   = odata;
    prev_chan   = chan;
    prev_popped = popped;
    prev_req    = en & ~empty;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++)
      if (bit_at(rd_snap, k) && fifo[k].size() != 0) void'(fifo[k].pop_front());
    if (rand_fill)
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 15) == 0) fill(k, $urandom_range(1, 4));
    ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_fix;
    en    = en_fix;
    drive_inputs();
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && !drained(); i++) step();
    check_eq(tag, drained(), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, d0;
    sel = 1'b0; max_burst = 16; rst_n = 1'b0; delivered = 0;
    rand_ready = 1'b0; rand_fill = 1'b0; ready_fix = 1'b1; en_fix = '1;
    for (int k = 0; k < N; k++) pops[k] = 0;

    for (int r = 0; r < 3; r++) begin
      empty = N'($urandom); en = N'($urandom); ready = 1'($urandom);
      data  = {$urandom, $urandom, $urandom, $urandom};
      #7;
      check_reset_outputs("rst");
    end
    ready = 1'b1; en = '1; drive_inputs();
    @(negedge clk); rst_n = 1'b1; model_reset();
    repeat (6) step();
    check_eq("idle_busy", busy, 0);

    // Lane 1 with three words.
    fill(1, 3); drive_inputs();
    p0 = pops[1]; d0 = delivered;
    repeat (10) step();
    check_eq("b_pops", pops[1] - p0, 3);
    check_eq("b_delivered", delivered - d0, 3);

    // All lanes full, 16-word bursts in strict rotation.
    for (int k = 0; k < N; k++) fill(k, 40);
    drive_inputs(); d0 = delivered;
    drain("c_drained", 400);
    check_eq("c_delivered", delivered - d0, 160);

    // Downstream stall mid-burst.
    for (int k = 0; k < N; k++) fill(k, 20);
    drive_inputs();
    repeat (6) step();
    ready_fix = 1'b0;
    repeat (6) step();
    ready_fix = 1'b1;
    drain("d_drained", 400);

    // Lane 2 disabled during its own burst.
    for (int k = 0; k < N; k++) fill(k, 30);
    drive_inputs();
    for (int i = 0; i < 200 && grant != 4'b0100; i++) step();
    check_eq("e_lane2_granted", grant, 4'b0100);
    en_fix = 4'b1011;
    step();
    p0 = pops[2];
    repeat (60) step();
    check_eq("e_lane2_frozen", pops[2] - p0, 0);
    en_fix = '1;
    drain("e_drained", 600);

    // Random traffic, backpressure and enable changes.
    rand_fill = 1'b1; rand_ready = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (i % 50 == 0) en_fix = N'($urandom);
      step();
    end
    rand_fill = 1'b0; rand_ready = 1'b0; en_fix = '1;
    drain("f_drained", 2500);

    // Asynchronous reset in the middle of a burst.
    for (int k = 0; k < N; k++) fill(k, 20);
    drive_inputs();
    for (int i = 0; i < 50 && !(grant != 0 && valid); i++) step();
    check_eq("g_in_burst", grant != 0 && valid, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("g_rst");
    @(negedge clk); rst_n = 1'b1; model_reset();
    step();
    check_eq("g_first_grant", grant, 4'b0001);
    drain("g_drained", 600);

    // Single-word bursts on the second instance.
    rst_n = 1'b0;
    #2;
    sel = 1'b1; max_burst = 1;
    fill(0, 6); fill(1, 6); drive_inputs();
    p0 = pops[0]; d0 = pops[1];
    @(negedge clk); rst_n = 1'b1; model_reset();
    drain("h_drained", 200);
    check_eq("h_pops0", pops[0] - p0, 6);
    check_eq("h_pops1", pops[1] - d0, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
